// File: rtl/onehot_encoder_reg.sv
// Registered one-hot to binary encoder with valid/ready handshake on both sides.
// Flags words that are not exactly one-hot and keeps a saturating count of them.
module onehot_encoder_reg #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_onehot,
    input  logic             clr_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_code,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_next;
    logic       in_xfer;
    logic       out_xfer;
    logic [2:0] enc_code;
    logic       enc_err;

    // The output register may be refilled in the same cycle it drains.
    always_comb begin
        in_ready  = !rst && ((state == EMPTY) || out_ready);
        out_valid = (state == FULL);
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
    end

    // Scanning downward lets the lowest set bit win when several are set.
    always_comb begin
        enc_code = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (in_onehot[i]) begin
                enc_code = 3'(i);
            end
        end
        enc_err = (in_onehot == 8'd0) || ((in_onehot & (in_onehot - 8'd1)) != 8'd0);
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_xfer && !in_xfer) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_code <= 3'd0;
            out_err  <= 1'b0;
        end else if (in_xfer) begin
            out_code <= enc_code;
            out_err  <= enc_err;
        end
    end

    // Clearing wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (in_xfer && enc_err && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: doc/onehot_encoder_reg.md
ONEHOT_ENCODER_REG -- requirements
Module: onehot_encoder_reg

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of the error counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream word present on in_onehot.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts the input word this cycle.
REQ-006 The block SHALL have port in_onehot, input, 8 bits: decoded line vector from the 3-to-8 decoder stage.
REQ-007 The block SHALL have port clr_cnt, input, 1 bit: synchronous clear of err_cnt.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_code/out_err hold a registered result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream consumes the result this cycle.
REQ-010 The block SHALL have port out_code, output, 3 bits: encoded index of the captured word.
REQ-011 The block SHALL have port out_err, output, 1 bit: captured word was not exactly one-hot.
REQ-012 The block SHALL have port err_cnt, output, CNT_W bits: saturating count of accepted erroneous words.

Function
REQ-013 The input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; the output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-014 The block SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 In EMPTY: input transfer -> FULL; otherwise stay EMPTY.
REQ-016 In FULL: output transfer without input transfer -> EMPTY; output and input transfer in the same cycle -> stay FULL with the new word loaded; no output transfer -> stay FULL with out_code/out_err held stable.
REQ-017 in_ready SHALL be combinational: 1 when EMPTY, or when FULL and out_ready=1; in_ready SHALL not depend on in_valid.
REQ-018 Latency SHALL be one cycle: a word accepted at edge N appears on out_code/out_err with out_valid=1 after edge N; sustained throughput SHALL be one word per cycle when out_ready=1.
REQ-019 Exactly one bit i set: out_code SHALL be i (0..7) and out_err SHALL be 0.
REQ-020 All bits zero: out_code SHALL be 3'b000 and out_err SHALL be 1.
REQ-021 Two or more bits set: out_code SHALL be the index of the lowest set bit and out_err SHALL be 1.
REQ-022 in_onehot SHALL be ignored (no state change) on any cycle without an input transfer.
REQ-023 err_cnt SHALL increment by 1 on each input transfer whose word sets out_err=1.
REQ-024 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 clr_cnt=1 SHALL set err_cnt to 0 at the edge, taking priority over a simultaneous increment.
REQ-026 out_code/out_err SHALL change only on an input transfer, never while out_valid=1 and out_ready=0.

Reset
REQ-027 rst=1 SHALL asynchronously force: FSM to EMPTY, out_valid=0, out_code=3'b000, out_err=0, err_cnt=0.
REQ-028 While rst=1, in_ready SHALL be 0; a word held in FULL when rst asserts SHALL be discarded and not counted.
REQ-029 The first input transfer SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-030 Reset, then in_onehot=8'b0000_0100, in_valid=1, out_ready=1 for one edge -> next cycle out_valid=1, out_code=3'd2, out_err=0, err_cnt=0.
REQ-031 Stream 8'h01,8'h02,...,8'h80 back-to-back with out_ready=1 -> out_code 0..7 on consecutive cycles, in_ready=1 throughout, no bubbles.
REQ-032 Accept 8'h00 then 8'b0010_1000 -> out_code=0/out_err=1, then out_code=3/out_err=1; err_cnt=2.
REQ-033 FULL with out_ready=0 for 5 cycles while in_valid=1 with changing in_onehot -> in_ready=0, out_code/out_err stable; out_ready=1 -> one transfer, next word loaded same edge.
REQ-034 CNT_W=2, accept 5 erroneous words -> err_cnt 1,2,3,3,3; clr_cnt=1 coincident with an erroneous transfer -> err_cnt=0.
REQ-035 Assert rst mid-cycle while FULL with out_ready=0 -> out_valid=0, out_code=0, out_err=0, err_cnt=0 immediately without a clock edge; normal acceptance resumes the first edge after release.
